// File: rtl/regbus_arb_pkg.sv
// Shared definitions for the HDMI register-bus arbiter slice.
// Optional feature macro used by the slice: REGARB_TIMEOUT_EN.
package regbus_pkg;

  localparam int unsigned REGBUS_AW = 8;
  localparam int unsigned REGBUS_DW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [REGBUS_AW-1:0] REGBUS_IDLE_ADDR    = '0;
  localparam logic                 REGBUS_IDLE_LAST    = 1'b1;
  localparam logic [REGBUS_DW-1:0] REGBUS_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/regbus_arb_if.sv
// Requester-side and downstream register-bus signals of the arbiter.
// slave: arbiter view; master: requesters plus downstream bus model.
interface regbus_arb_if
  import regbus_pkg::*;
#(
  parameter int unsigned N = 3
);
  logic [N*REGBUS_AW-1:0] rq_addr;
  logic [N*REGBUS_DW-1:0] rq_wrdata;
  logic [N-1:0]           rq_req;
  logic [N-1:0]           rq_wr;
  logic [N-1:0]           rq_last;
  logic [N-1:0]           rq_ack;
  logic [N-1:0]           rq_err;
  logic [REGBUS_DW-1:0]   rq_rddata;
  logic [N-1:0]           grant;

  logic [REGBUS_AW-1:0]   hdaddr;
  logic [REGBUS_DW-1:0]   hdwrdata;
  logic                   hdreq;
  logic                   hdwr;
  logic                   hdlast;
  logic [REGBUS_DW-1:0]   hdrddata;
  logic                   hdack;
  logic                   hderr;

  modport slave (
    input  rq_addr, rq_wrdata, rq_req, rq_wr, rq_last, hdrddata, hdack, hderr,
    output rq_ack, rq_err, rq_rddata, grant, hdaddr, hdwrdata, hdreq, hdwr, hdlast
  );

  modport master (
    output rq_addr, rq_wrdata, rq_req, rq_wr, rq_last, hdrddata, hdack, hderr,
    input  rq_ack, rq_err, rq_rddata, grant, hdaddr, hdwrdata, hdreq, hdwr, hdlast
  );
endinterface

// File: rtl/regbus_arb_rr_pick.sv
// Combinational round-robin picker: first set request after i_prev, wrapping mod N.
module rr_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_prev,
  output logic         o_valid,
  output logic [W-1:0] o_index
);

  logic [W-1:0] w_cand;

  // Scan prev+1 .. prev+N; the first hit wins, prev itself is checked last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = W'((32'(i_prev) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/regbus_arb.sv
// Round-robin, burst-locking arbiter sharing the HDMI transmitter register bus.
// Optional transfer timeout enabled by defining REGARB_TIMEOUT_EN.
module regbus_arb
  import regbus_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned TIMEOUT = 4000000
) (
  input  logic          clk,
  input  logic          rst,
  regbus_arb_if.slave   bus
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || TIMEOUT == 0) begin : g_param_check
    $error("regbus_arb: N must be 2..8 and TIMEOUT non-zero");
  end

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_owner, w_owner_nxt;
  logic [W-1:0] r_prev,  w_prev_nxt;
  logic         r_locked, w_locked_nxt;
  logic         w_pick_valid;
  logic [W-1:0] w_pick_idx;
  logic [W+2:0] w_sel;

  assign w_sel = {r_owner, 3'b000};

  rr_pick #(.N(N), .W(W)) u_pick (
    .i_req   (bus.rq_req),
    .i_prev  (r_prev),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

`ifdef REGARB_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        w_tmo_hit;

  // A real ack in the expiry cycle wins, so the timeout only fires without one.
  assign w_tmo_hit = (r_state == BUSY) && !bus.hdack && (r_tmo_cnt == 32'(TIMEOUT - 1));

  // Cycles the owner has waited for an ack; restarts per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE || bus.hdack) begin
      r_tmo_cnt <= '0;
    end else if (bus.rq_req[r_owner]) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`endif

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_prev   <= W'(N - 1);
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_prev   <= w_prev_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Next-state logic and the owner-selected bus mux.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_prev_nxt    = r_prev;
    w_locked_nxt  = r_locked;

    bus.grant     = '0;
    bus.hdreq     = 1'b0;
    bus.hdaddr    = REGBUS_IDLE_ADDR;
    bus.hdwrdata  = '0;
    bus.hdwr      = 1'b0;
    bus.hdlast    = REGBUS_IDLE_LAST;
    bus.rq_ack    = '0;
    bus.rq_err    = '0;
    bus.rq_rddata = '0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt  = w_pick_idx;
          w_locked_nxt = 1'b0;
          w_state_nxt  = BUSY;
        end
      end

      BUSY: begin
        bus.grant[r_owner]  = 1'b1;
        bus.hdreq           = bus.rq_req[r_owner];
        bus.hdaddr          = bus.rq_addr[w_sel +: REGBUS_AW];
        bus.hdwrdata        = bus.rq_wrdata[w_sel +: REGBUS_DW];
        bus.hdwr            = bus.rq_wr[r_owner];
        bus.hdlast          = bus.rq_last[r_owner];
        bus.rq_ack[r_owner] = bus.hdack;
        bus.rq_err[r_owner] = bus.hderr;
        if (bus.hdack) begin
          bus.rq_rddata = bus.hdrddata;
        end

        if (bus.hdack) begin
          if (bus.rq_last[r_owner]) begin
            w_state_nxt  = IDLE;
            w_prev_nxt   = r_owner;
            w_locked_nxt = 1'b0;
          end else begin
            w_locked_nxt = 1'b1;
          end
        end else if (!bus.rq_req[r_owner] && !r_locked) begin
          w_state_nxt = IDLE;
          w_prev_nxt  = r_owner;
        end

`ifdef REGARB_TIMEOUT_EN
        // Abandon the transfer: synthesize an error ack and release the bus.
        if (w_tmo_hit) begin
          bus.rq_ack[r_owner] = 1'b1;
          bus.rq_err[r_owner] = 1'b1;
          bus.rq_rddata       = REGBUS_TIMEOUT_DATA;
          bus.hdreq           = 1'b0;
          w_state_nxt         = IDLE;
          w_prev_nxt          = r_owner;
          w_locked_nxt        = 1'b0;
        end
`endif
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/regbus_arb.md
Name: regbus_arb

Overview:
- Shares the single 8-bit HDMI transmitter register bus (addr/wrdata/req/wr/last/rddata/ack/err) among N requesters, e.g. the HDMI init/hot-plug sequencer, an EDID reader and a debug peek port.
- Uses round-robin arbitration with burst locking. A requester holds ownership across transfers with last=0.
- Sits between the requesters and the register-bus master, in the `clk` domain.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 4000000, cycles without ack before a transfer is abandoned; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rq_addr  in  8*N  per-requester register address; requester i uses [8i+7:8i].
- rq_wrdata  in  8*N  per-requester write data.
- rq_req  in  N  per-requester transfer request, held until ack.
- rq_wr  in  N  per-requester write (1) / read (0).
- rq_last  in  N  1 = release the bus after this transfer; 0 = keep ownership (burst).
- rq_ack  out  N  per-requester transfer done, one cycle.
- rq_err  out  N  per-requester error, valid with rq_ack.
- rq_rddata  out  8  read data, broadcast; valid with rq_ack.
- grant  out  N  one-hot current owner; 0 when idle.
- hdaddr  out  8  downstream address.
- hdwrdata  out  8  downstream write data.
- hdreq  out  1  downstream request.
- hdwr  out  1  downstream write.
- hdlast  out  1  downstream last.
- hdrddata  in  8  downstream read data.
- hdack  in  1  downstream ack.
- hderr  in  1  downstream error.

Behaviour:
- Registered state:
  - state ∈ {IDLE, BUSY}.
  - owner (clog2 N bits).
  - prev (previous owner).
  - locked flag.
- Reset values: state=IDLE, owner=0, prev=N-1 (requester 0 wins first), locked=0. Downstream and requester-side outputs then take their IDLE values.
- IDLE:
  - grant=0, hdreq=0, hdaddr=0, hdwrdata=0, hdwr=0, hdlast=1, rq_ack=0, rq_err=0.
  - If any rq_req bit is set: pick the first set bit, scanning prev+1, prev+2, … mod N.
  - Register it as owner, clear locked, go to BUSY.
  - Arbitration latency: one clock from request to grant/hdreq.
- BUSY:
  - Downstream outputs are combinational muxes of the owner's inputs; grant[owner]=1.
  - rq_ack[owner]=hdack, rq_err[owner]=hderr, rq_rddata=hdrddata (same cycle). Non-owners get ack=0 and err=0.
- On hdack in BUSY:
  - rq_last[owner]=1: go to IDLE, prev←owner, locked←0.
  - rq_last[owner]=0: stay in BUSY, locked←1.
- Request dropped in BUSY (rq_req[owner]=0): hdreq=0.
  - locked=0 (requester withdrew before its first ack): go to IDLE, prev←owner.
  - locked=1: hold ownership indefinitely until the owner's next transfer completes with last=1.
- Handover gap: at least one IDLE cycle between owners, and after any last=1 ack, including re-grant to the same requester.
- Fairness: requests from non-owners are ignored during BUSY and have no effect until IDLE. No starvation: each requester is served within N grants.
- Reset asserted mid-transfer: immediate return to reset values, hdreq drops asynchronously. No ack is generated.
- hderr is not special-cased: an error ack still follows the rq_last rules.
- rq_rddata is 0 when there is no ack.

Optional Feature:
- Macro: REGARB_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to BUSY and on every hdack. It increments each BUSY cycle with hdreq=1 and hdack=0.
  - When the counter reaches TIMEOUT-1, that cycle drives rq_ack[owner]=1, rq_err[owner]=1, rq_rddata=8'hFF and hdreq=0.
  - Next state is IDLE regardless of rq_last or locked; prev←owner.
  - A simultaneous real hdack takes precedence and the timeout is not flagged.
- Without the macro: no counter, TIMEOUT is ignored, and a transfer waits forever.

Decomposition:
- Package regbus_pkg holds:
  - REGBUS_AW=8, REGBUS_DW=8.
  - State encoding (IDLE=0, BUSY=1).
  - Idle defaults: address 0, last 1.
  - REGBUS_TIMEOUT_DATA=8'hFF.
- Sub-module rr_pick: combinational round-robin picker. Inputs req[N] and prev; outputs valid and index.
- Muxing and the FSM stay in regbus_arb.

Test Plan:
- Single requester 1 writes addr 8'h41 data 8'h10, last=1, hdack after 3 cycles:
  - hdreq rises one cycle after rq_req.
  - hdaddr=8'h41, hdwrdata=8'h10, hdwr=1.
  - rq_ack[1] pulses in the same cycle as hdack.
  - grant returns to 0 the next cycle.
- All three requesters request continuously, each with last=1: grant order is 0,1,2,0,1,2, with exactly one IDLE cycle between grants.
- Burst from requester 2 (reads 8'h42, 8'h43 with last=0,1) while requester 0 also requests:
  - Requester 0 is not granted until after the second ack.
  - rq_rddata matches the hdrddata values 8'hC0 and 8'h5A.
- Requester 1 drops rq_req before any ack (locked=0): the FSM returns to IDLE and requester 2, which is pending, is granted next.
- Reset asserted with hdreq=1 mid-transfer: hdreq, grant and rq_ack go to 0 without waiting for a clock edge. After release, requester 0 wins first.
- With REGARB_TIMEOUT_EN and TIMEOUT=16, no hdack:
  - On the 16th BUSY cycle: rq_ack=1, rq_err=1, rq_rddata=8'hFF, hdreq=0.
  - The FSM is in IDLE the next cycle.
  - Repeat with hdack arriving on exactly that cycle: rq_err=hderr and rq_rddata=hdrddata.
